hex_capture_bank: RTL and testbench

//  Parametrised registered 7-seg/LED display bank: next generation of the per-digit enable-latched hex display.

---
 rtl/hex_capture_bank.sv | 183 ++++++++++++++++++
 tb/tb_hex_capture_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_capture_bank.sv
// hex_capture_bank: registered multi-digit 7-seg / LED display bank.
// Captures a hex word and LED vector on a debounced active-low key press.
// Ports:
//   CLOCK_50      - system clock, rising edge
//   reset         - asynchronous active-high reset
//   cap_n         - raw active-low push-button (asynchronous)
//   mode          - 00 LIVE, 01 CAPTURE, 10 CAPTURE_BLINK, 11 OFF
//   blank_lz      - blank leading zero digits (digit 0 always shown)
//   data          - hex word, nibble i drives digit i
//   led_in        - LED vector captured alongside data
//   HEX           - active-low gfedcba segments, 7 bits per digit
//   LEDR          - captured LED vector (forced 0 in OFF)
//   cap_pulse     - one-cycle strobe per accepted press
//   capture_count - accepted press count, wraps at 256
module hex_capture_bank #(
    parameter int NUM_DIGITS        = 6,
    parameter int LED_WIDTH         = 10,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int BLINK_HALF_PERIOD = 12500000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    cap_n,
    input  logic [1:0]              mode,
    input  logic                    blank_lz,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [LED_WIDTH-1:0]    led_in,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [LED_WIDTH-1:0]    LEDR,
    output logic                    cap_pulse,
    output logic [7:0]              capture_count
);

    typedef enum logic [1:0] {
        M_LIVE  = 2'b00,
        M_CAP   = 2'b01,
        M_BLINK = 2'b10,
        M_OFF   = 2'b11
    } mode_e;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLAST = BW'(BLINK_HALF_PERIOD - 1);

    logic                    sync1_q, sync2_q;
    logic                    deb_q, deb_d;
    logic                    deb_prev_q;
    logic [DW-1:0]           dcnt_q, dcnt_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic                    blink_on_q, blink_on_d;
    logic [4*NUM_DIGITS-1:0] data_snap_q, data_snap_d;
    logic [LED_WIDTH-1:0]    led_snap_q, led_snap_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    pulse_q;
    logic [7:0]              count_q, count_d;
    logic                    press;
    logic                    lead;
    logic [3:0]              nib;
    logic [6:0]              seg;
    logic                    hide;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Debounce: level follows the synced key only after a full stable run.
    always_comb begin
        dcnt_d = dcnt_q;
        deb_d  = deb_q;
        if (sync2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DLAST) begin
            deb_d  = sync2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Press = debounced level seen falling on the previous edge.
    assign press = deb_prev_q & ~deb_q;

    always_comb begin
        data_snap_d = data_snap_q;
        led_snap_d  = led_snap_q;
        if (press || mode == M_LIVE) begin
            data_snap_d = data;
            led_snap_d  = led_in;
        end
        count_d = count_q + {7'd0, press};
    end

    // Blink phase runs in every mode; a press restarts it in the ON phase.
    always_comb begin
        bcnt_d     = bcnt_q + 1'b1;
        blink_on_d = blink_on_q;
        if (press) begin
            bcnt_d     = '0;
            blink_on_d = 1'b1;
        end else if (bcnt_q == BLAST) begin
            bcnt_d     = '0;
            blink_on_d = ~blink_on_q;
        end
    end

    // Walk from the MSD down; blanking stops at the first non-zero nibble.
    always_comb begin
        hex_d = '1;
        lead  = blank_lz;
        nib   = '0;
        seg   = '1;
        hide  = (mode == M_OFF) || (mode == M_BLINK && !blink_on_q);
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = data_snap_q[4*i +: 4];
            seg = seg7(nib);
            if (lead && nib == 4'h0 && i > 0) begin
                seg = 7'h7F;
            end else begin
                lead = 1'b0;
            end
            if (hide) begin
                seg = 7'h7F;
            end
            hex_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_q       <= 1'b1;
            deb_prev_q  <= 1'b1;
            dcnt_q      <= '0;
            bcnt_q      <= '0;
            blink_on_q  <= 1'b1;
            data_snap_q <= '0;
            led_snap_q  <= '0;
            hex_q       <= '1;
            pulse_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            sync1_q     <= cap_n;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            blink_on_q  <= blink_on_d;
            data_snap_q <= data_snap_d;
            led_snap_q  <= led_snap_d;
            hex_q       <= hex_d;
            pulse_q     <= press;
            count_q     <= count_d;
        end
    end

    assign HEX           = hex_q;
    assign LEDR          = (mode == M_OFF) ? '0 : led_snap_q;
    assign cap_pulse     = pulse_q;
    assign capture_count = count_q;

endmodule

// File: tb/tb_hex_capture_bank.sv
// tb_hex_capture_bank: directed self-checking bench for hex_capture_bank.
// Small debounce/blink parameters; checks sampled on the falling edge.
module tb_hex_capture_bank;

    localparam int ND = 6;
    localparam int LW = 10;
    localparam int DB = 4;
    localparam int BH = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cap_n = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic              blank_lz = 1'b0;
    logic [4*ND-1:0]   data = '0;
    logic [LW-1:0]     led_in = '0;
    logic [7*ND-1:0]   hex;
    logic [LW-1:0]     ledr;
    logic              pulse;
    logic [7:0]        cnt;

    int passed = 0;
    int total  = 0;

    localparam logic [7*ND-1:0] ALLOFF = {ND{7'h7F}};

    hex_capture_bank #(
        .NUM_DIGITS(ND),
        .LED_WIDTH(LW),
        .DEBOUNCE_CYCLES(DB),
        .BLINK_HALF_PERIOD(BH)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .cap_n(cap_n),
        .mode(mode),
        .blank_lz(blank_lz),
        .data(data),
        .led_in(led_in),
        .HEX(hex),
        .LEDR(ledr),
        .cap_pulse(pulse),
        .capture_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: pulse lands DB+3 edges after the fall, then release.
    task automatic press();
        cap_n = 1'b0;
        step(DB + 4);
        cap_n = 1'b1;
        step(DB + 4);
    endtask

    logic [7*ND-1:0] val;
    int              npulse;
    int              at;
    bit              found;

    initial begin
        // 1. async reset
        #2 rst = 1'b1;
        #1;
        chk("rst_hex", 64'(hex), 64'(ALLOFF));
        chk("rst_ledr", 64'(ledr), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_pulse", 64'(pulse), 64'd0);
        step(1);
        rst = 1'b0;

        // 2. LIVE, two-edge latency
        mode = 2'b00;
        data = 24'h12345A;
        step(1);
        chk("live_1edge", 64'(hex), 64'({ND{7'h40}}));
        step(1);
        chk("live_2edge", 64'(hex),
            64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h08}));

        // 3. CAPTURE with glitch then clean press
        mode   = 2'b01;
        data   = 24'h00ABCD;
        led_in = 10'h155;
        cap_n  = 1'b0;
        step(2);
        cap_n = 1'b1;
        step(3);
        cap_n  = 1'b0;
        npulse = 0;
        at     = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (pulse) begin
                npulse++;
                at = k;
            end
        end
        cap_n = 1'b1;
        chk("glitch_npulse", 64'(npulse), 64'd1);
        chk("pulse_lat", 64'(at), 64'd7);
        chk("cnt1", 64'(cnt), 64'd1);
        chk("ledr155", 64'(ledr), 64'h155);
        val = {7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21};
        chk("cap_hex", 64'(hex), 64'(val));
        data = 24'h777777;
        step(DB + 4);
        chk("cap_hold", 64'(hex), 64'(val));

        // 4. leading-zero blanking
        blank_lz = 1'b1;
        data     = 24'h000000;
        press();
        chk("lz_zero", 64'(hex), 64'({{5{7'h7F}}, 7'h40}));
        data = 24'h00F001;
        press();
        val = {7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h79};
        chk("lz_f001", 64'(hex), 64'(val));
        chk("cnt3", 64'(cnt), 64'd3);

        // 5. CAPTURE_BLINK: find start of an OFF run
        mode  = 2'b10;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1);
            if (hex !== ALLOFF) found = 1'b1;
        end
        chk("blink_on_seen", 64'(found), 64'd1);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1);
            if (hex === ALLOFF) found = 1'b1;
        end
        chk("blink_off_seen", 64'(found), 64'd1);
        for (int k = 0; k < 2; k++) begin
            step(1);
            chk("blink_off_run", 64'(hex), 64'(ALLOFF));
        end
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("blink_on_run", 64'(hex), 64'(val));
        end
        step(1);
        chk("blink_off_again", 64'(hex), 64'(ALLOFF));

        // press timed to land mid OFF phase
        data  = 24'h00BEEF;
        cap_n = 1'b0;
        step(DB + 3);
        chk("blink_pulse", 64'(pulse), 64'd1);
        chk("blink_pulse_hex", 64'(hex), 64'(ALLOFF));
        val = {7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E};
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("blink_restart_on", 64'(hex), 64'(val));
        end
        step(1);
        chk("blink_restart_off", 64'(hex), 64'(ALLOFF));
        cap_n = 1'b1;
        step(DB + 4);
        chk("cnt4", 64'(cnt), 64'd4);

        // OFF mode: blank outputs, still capture, snapshot returns after
        mode = 2'b11;
        step(1);
        chk("off_hex", 64'(hex), 64'(ALLOFF));
        chk("off_ledr", 64'(ledr), 64'd0);
        blank_lz = 1'b0;
        data     = 24'h000123;
        led_in   = 10'h3FF;
        press();
        chk("off_cnt5", 64'(cnt), 64'd5);
        chk("off_hex2", 64'(hex), 64'(ALLOFF));
        mode = 2'b01;
        step(1);
        chk("off_exit_hex", 64'(hex),
            64'({7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}));
        chk("off_exit_ledr", 64'(ledr), 64'h3FF);

        // 6. reset mid-debounce
        cap_n = 1'b0;
        step(4);
        rst   = 1'b1;
        cap_n = 1'b1;
        #1;
        chk("midrst_cnt", 64'(cnt), 64'd0);
        chk("midrst_hex", 64'(hex), 64'(ALLOFF));
        chk("midrst_ledr", 64'(ledr), 64'd0);
        step(1);
        rst    = 1'b0;
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (pulse) npulse++;
        end
        chk("midrst_nopulse", 64'(npulse), 64'd0);
        chk("midrst_cnt2", 64'(cnt), 64'd0);

        // counter wrap
        for (int k = 0; k < 255; k++) press();
        chk("cnt255", 64'(cnt), 64'd255);
        press();
        chk("cnt_wrap", 64'(cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
